// File: rtl/split_data_if.sv
// Stream bundle for the read-path width down-converter: wide words in,
// narrow pixels out. The converter is the slave of the word stream and
// drives the pixel stream; the master modport is the surrounding logic.
interface split_data_if #(
   parameter int ISIZE = 256,
   parameter int OSIZE = 24
);
   logic             ivalid;
   logic             iready;
   logic [ISIZE-1:0] idata;
   logic             ilast;
   logic             ialign;
   logic             ovalid;
   logic             oready;
   logic [OSIZE-1:0] odata;
   logic             olast;

   modport slave (
      input  ivalid, idata, ilast, ialign, oready,
      output iready, ovalid, odata, olast
   );

   modport master (
      output ivalid, idata, ilast, ialign, oready,
      input  iready, ovalid, odata, olast
   );
endinterface

// File: rtl/split_data.sv
// Width down-converter: wide memory words become a gap-free stream of
// narrow pixels. Leftover bits of one word are carried into the first pixel
// of the next; the last word of a line flushes any partial pixel so the next
// line starts aligned at bit 0.
module split_data #(
   parameter int ISIZE = 256,
   parameter int OSIZE = 24
) (
   input  logic         clk_i,
   input  logic         rst_i,
   split_data_if.slave  bus
);
   localparam int SW = ISIZE + OSIZE - 1;
   localparam int FW = $clog2(ISIZE + OSIZE);
   localparam logic [FW-1:0] OSZ  = FW'(OSIZE);
   localparam logic [FW-1:0] OSZ2 = FW'(2 * OSIZE);
   localparam logic [FW-1:0] ISZ  = FW'(ISIZE);

   logic [SW-1:0] sbuf_q, sbuf_d;
   logic [SW-1:0] sbuf_shift;
   logic [SW-1:0] keep_mask;
   logic [SW-1:0] word_ext;
   logic [FW-1:0] fill_q, fill_d;
   logic [FW-1:0] fill_after;
   logic          last_pend_q, last_pend_d;
   logic          ovalid_q, ovalid_d;
   logic          olast_q, olast_d;
   logic          ofire;
   logic          ifire;
   logic          iready;

   assign ofire = ovalid_q & bus.oready;

   // Accept a word only when the buffer will hold less than one pixel after
   // this cycle's pixel fire. When ofire is true fill_q >= OSIZE, so the
   // test fill_q < 2*OSIZE is the same as (fill_q - OSIZE) < OSIZE without
   // risking underflow. The oready->iready path removes bubbles between words.
   always_comb begin
      iready = ~rst_i & ~bus.ialign & ~last_pend_q &
               ((fill_q < OSZ) | (ofire & (fill_q < OSZ2)));
   end

   assign ifire = bus.ivalid & iready;

   // Next state: apply the pixel fire first, then place a new word directly
   // above the surviving bits; ialign overrides everything.
   always_comb begin
      sbuf_shift  = sbuf_q;
      fill_after  = fill_q;
      last_pend_d = last_pend_q;
      if (ofire) begin
         sbuf_shift = sbuf_q >> OSIZE;
         if (olast_q) begin
            // End of line: the partial pixel left behind is discarded.
            fill_after  = '0;
            last_pend_d = 1'b0;
         end else begin
            fill_after = fill_q - OSZ;
         end
      end

      // Keep only valid bits so stale data never ORs into a new word.
      keep_mask = ~({SW{1'b1}} << fill_after);
      word_ext  = SW'(bus.idata) << fill_after;
      sbuf_d    = sbuf_shift & keep_mask;
      fill_d    = fill_after;

      if (ifire) begin
         sbuf_d = sbuf_d | word_ext;
         fill_d = fill_after + ISZ;
         if (bus.ilast) begin
            last_pend_d = 1'b1;
         end
      end

      if (bus.ialign) begin
         sbuf_d      = '0;
         fill_d      = '0;
         last_pend_d = 1'b0;
      end

      ovalid_d = (fill_d >= OSZ);
      olast_d  = ovalid_d & last_pend_d & (fill_d < OSZ2);
   end

   // State and registered outputs; reset clears everything immediately.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sbuf_q      <= '0;
         fill_q      <= '0;
         last_pend_q <= 1'b0;
         ovalid_q    <= 1'b0;
         olast_q     <= 1'b0;
      end else begin
         sbuf_q      <= sbuf_d;
         fill_q      <= fill_d;
         last_pend_q <= last_pend_d;
         ovalid_q    <= ovalid_d;
         olast_q     <= olast_d;
      end
   end

   assign bus.iready = iready;
   assign bus.ovalid = ovalid_q;
   assign bus.olast  = olast_q;
   assign bus.odata  = sbuf_q[OSIZE-1:0];

endmodule

// File: tb/tb_split_data.sv
// Directed bench for split_data (ISIZE=256, OSIZE=24).
module tb_split_data;
   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   logic [255:0] ws [3];

   split_data_if #(.ISIZE(256), .OSIZE(24)) bus ();

   split_data #(.ISIZE(256), .OSIZE(24)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Three-word stream of 32 pixels; bp=1 randomises oready.
   task automatic run_stream(input bit bp, input string tag);
      logic [767:0] strm;
      logic [23:0]  prev_d;
      logic         prev_l;
      bit           prev_hold;
      bit           of, inf;
      int           pix, widx, fill_m;
      strm      = {ws[2], ws[1], ws[0]};
      pix       = 0;
      widx      = 0;
      fill_m    = 0;
      prev_hold = 0;
      prev_d    = '0;
      prev_l    = 1'b0;
      for (int c = 0; c < 400 && pix < 32; c++) begin
         @(negedge clk);
         bus.ivalid = (widx < 3);
         bus.idata  = (widx < 3) ? ws[widx] : '0;
         bus.ilast  = 1'b0;
         bus.ialign = 1'b0;
         bus.oready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (prev_hold) begin
            chk({tag, "_hold_data"}, bus.odata, prev_d);
            chk({tag, "_hold_last"}, bus.olast, prev_l);
         end
         chk({tag, "_ovalid"}, bus.ovalid, (fill_m >= 24));
         if (!bp)
            chk({tag, "_iready"}, bus.iready, (c == 0 || c == 10 || c == 21 || c >= 32));
         of  = bus.ovalid & bus.oready;
         inf = bus.ivalid & bus.iready;
         if (bus.ovalid) chk({tag, "_olast"}, bus.olast, 1'b0);
         if (of) begin
            chk({tag, "_pix"}, bus.odata, strm[pix*24 +: 24]);
            if (!bp && pix == 10) chk({tag, "_carry10"}, bus.odata, {ws[1][7:0], ws[0][255:240]});
            if (!bp && pix == 21) chk({tag, "_carry21"}, bus.odata, {ws[2][15:0], ws[1][255:248]});
            pix++;
            fill_m -= 24;
         end
         prev_hold = bus.ovalid & ~bus.oready;
         prev_d    = bus.odata;
         prev_l    = bus.olast;
         if (inf) begin
            chk({tag, "_loadgate"}, (fill_m < 24), 1'b1);
            $display("%s: word %0d accepted in cycle %0d", tag, widx, c);
            fill_m += 256;
            widx++;
         end
      end
      chk({tag, "_npix"}, pix, 32);
      chk({tag, "_nword"}, widx, 3);
   endtask

   // One line of nw words (1 or 2), last word flagged with ilast.
   task automatic feed_line(input logic [255:0] a, input logic [255:0] b, input int nw, input string tag);
      logic [511:0] strm;
      int  npix, pix, widx;
      bit  lp, done, of;
      strm = {b, a};
      npix = (nw == 1) ? 10 : 21;
      pix  = 0;
      widx = 0;
      lp   = 0;
      done = 0;
      for (int c = 0; c < 100 && !done; c++) begin
         @(negedge clk);
         bus.ivalid = (widx < nw);
         bus.idata  = (widx == 0) ? a : b;
         bus.ilast  = (widx == nw - 1);
         bus.ialign = 1'b0;
         bus.oready = 1'b1;
         #1;
         if (c == 0) chk({tag, "_first_irdy"}, bus.iready, 1'b1);
         if (lp) chk({tag, "_irdy_held"}, bus.iready, 1'b0);
         of = bus.ovalid & bus.oready;
         if (of) begin
            chk({tag, "_pix"}, bus.odata, strm[pix*24 +: 24]);
            chk({tag, "_olast"}, bus.olast, (pix == npix - 1));
            if (bus.olast) done = 1;
            pix++;
         end
         if (bus.ivalid & bus.iready) begin
            $display("%s: word %0d accepted in cycle %0d", tag, widx, c);
            if (bus.ilast) lp = 1;
            widx++;
         end
      end
      chk({tag, "_npix"}, pix, npix);
   endtask

   initial begin
      ws[0] = 256'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0_13579bdf_2468ace0_fedcba98_76543210;
      ws[1] = 256'ha1b2c3d4_e5f60718_293a4b5c_6d7e8f90_deadbeef_cafef00d_01234567_89abcdef;
      ws[2] = 256'h55aa33cc_0ff0f00f_c0ffee11_badc0de5_7777aaaa_12344321_9e8d7c6b_5a493827;

      rst        = 1'b1;
      bus.ivalid = 1'b0;
      bus.idata  = '0;
      bus.ilast  = 1'b0;
      bus.ialign = 1'b0;
      bus.oready = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ovalid", bus.ovalid, 1'b0);
      chk("rst_olast",  bus.olast,  1'b0);
      chk("rst_odata",  bus.odata,  24'h0);
      chk("rst_iready", bus.iready, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rel_iready", bus.iready, 1'b1);

      // Ratio stream
      run_stream(1'b0, "ratio");

      // Single-word line, then a two-word line
      feed_line(ws[1], ws[2], 1, "line1");
      feed_line(ws[0], ws[1], 2, "line2");
      @(negedge clk);
      bus.ivalid = 1'b0;
      #1;
      chk("line2_fill0_ovalid", bus.ovalid, 1'b0);
      chk("line2_fill0_iready", bus.iready, 1'b1);

      // Backpressure
      run_stream(1'b1, "bp");
      @(negedge clk);
      bus.oready = 1'b1;

      // ialign mid-word
      @(negedge clk);
      bus.ivalid = 1'b1;
      bus.idata  = ws[2];
      bus.oready = 1'b1;
      #1;
      chk("align_load_irdy", bus.iready, 1'b1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         bus.ivalid = 1'b0;
         #1;
         chk("align_pre_ovalid", bus.ovalid, 1'b1);
         chk("align_pre_pix", bus.odata, ws[2][k*24 +: 24]);
      end
      @(negedge clk);
      bus.ialign = 1'b1;
      #1;
      chk("align_irdy_low", bus.iready, 1'b0);
      @(negedge clk);
      bus.ialign = 1'b0;
      bus.ivalid = 1'b1;
      bus.idata  = ws[0];
      #1;
      chk("align_ovalid_drop", bus.ovalid, 1'b0);
      chk("align_irdy_high", bus.iready, 1'b1);
      @(negedge clk);
      bus.ivalid = 1'b0;
      #1;
      chk("align_restart_ovalid", bus.ovalid, 1'b1);
      chk("align_restart_pix", bus.odata, ws[0][23:0]);
      @(negedge clk);
      bus.ialign = 1'b1;
      @(negedge clk);
      bus.ialign = 1'b0;
      #1;
      chk("align_flush_ovalid", bus.ovalid, 1'b0);

      // Reset mid-line
      @(negedge clk);
      bus.ivalid = 1'b1;
      bus.idata  = ws[1];
      bus.oready = 1'b1;
      @(negedge clk);
      bus.ivalid = 1'b0;
      @(negedge clk);
      #2;
      chk("midrst_pre_ovalid", bus.ovalid, 1'b1);
      rst = 1'b1;
      #1;
      chk("midrst_ovalid", bus.ovalid, 1'b0);
      chk("midrst_olast",  bus.olast,  1'b0);
      chk("midrst_odata",  bus.odata,  24'h0);
      chk("midrst_iready", bus.iready, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_rel_iready", bus.iready, 1'b1);
      run_stream(1'b0, "rerun");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
